// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reaction_pkg;

    localparam int TIME_W  = 20;
    localparam int TOTAL_W = 24;
    localparam int LED_W   = 10;

    // Phase encodings; these are the values presented on the phase output.
    localparam logic [2:0] PH_IDLE      = 3'd0;
    localparam logic [2:0] PH_ARM       = 3'd1;
    localparam logic [2:0] PH_WAIT_USER = 3'd2;
    localparam logic [2:0] PH_RECORD    = 3'd3;
    localparam logic [2:0] PH_GAP       = 3'd4;
    localparam logic [2:0] PH_FOUL      = 3'd5;
    localparam logic [2:0] PH_FINISH    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = PH_IDLE,
        S_ARM       = PH_ARM,
        S_WAIT_USER = PH_WAIT_USER,
        S_RECORD    = PH_RECORD,
        S_GAP       = PH_GAP,
        S_FOUL      = PH_FOUL,
        S_FINISH    = PH_FINISH
    } state_t;

    localparam logic [TIME_W-1:0] BEST_INIT = 20'hFFFFF;
    localparam logic [LED_W-1:0]  LED_BLANK = '0;

    // Fold a 4-bit random nibble into the 0..9 switch range.
    function automatic logic [3:0] wrap_target(input logic [3:0] r);
        return (r >= 4'd10) ? (r - 4'd10) : r;
    endfunction

endpackage

// File: rtl/target_decode.sv
// Decodes the target index into a one-hot LED pattern and classifies the switches.
// Latency: purely combinational.
// Backpressure: none.
// Ports: target (0..9), switch (10 user switches) -> led (one-hot target),
//        hit (exactly the target switch set), wrong (any non-target switch set).
module target_decode
    import reaction_pkg::*;
(
    input  logic [3:0]       target,
    input  logic [LED_W-1:0] switch,
    output logic [LED_W-1:0] led,
    output logic             hit,
    output logic             wrong
);

    // Out-of-range targets shift the bit off the top and give a blank display.
    assign led   = (target < 4'd10) ? (10'd1 << target) : LED_BLANK;
    assign hit   = (led != LED_BLANK) && (switch == led);
    assign wrong = |(switch & ~led);

endmodule

// File: rtl/round_sequencer.sv
// Reaction-timer session sequencer: random delay, target LED, timing and score keeping.
// Latency: all outputs registered; state and results update one clock after the causing input.
// Backpressure: none; inputs are sampled every cycle, start is ignored in RECORD/GAP.
// Ports: clk, rst (async, active-high), start, switch, rand_num, count_bin in;
//        clreset (shared counter hold), led, phase, round_idx, last_time, best, total,
//        false_start, done out.
module round_sequencer
    import reaction_pkg::*;
#(
    parameter int          ROUNDS     = 5,
    parameter logic [19:0] TIMEOUT_MS = 20'd9999,
    parameter logic [14:0] MIN_DELAY  = 15'h0400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LED_W-1:0]    switch,
    input  logic [14:0]         rand_num,
    input  logic [TIME_W-1:0]   count_bin,
    output logic                clreset,
    output logic [LED_W-1:0]    led,
    output logic [2:0]          phase,
    output logic [2:0]          round_idx,
    output logic [TIME_W-1:0]   last_time,
    output logic [TIME_W-1:0]   best,
    output logic [TOTAL_W-1:0]  total,
    output logic                false_start,
    output logic                done
);

    state_t               state_q, state_d;
    logic [TIME_W-1:0]    delay_q;
    logic [3:0]           target_q;
    logic [TIME_W-1:0]    rec_time_q, rec_time_d;
    logic                 arm_entry;
    logic                 clear_results;
    logic                 wait_entry;
    logic                 clreset_d;
    logic                 sw_idle;
    logic                 timed_out;
    logic [LED_W-1:0]     dec_led;
    logic                 dec_hit;
    logic                 dec_wrong;
    logic [TOTAL_W:0]     sum_w;

    target_decode u_target_decode (
        .target (target_q),
        .switch (switch),
        .led    (dec_led),
        .hit    (dec_hit),
        .wrong  (dec_wrong)
    );

    assign sw_idle   = (switch == LED_BLANK);
    assign timed_out = (count_bin >= TIMEOUT_MS);
    assign phase     = state_q;

    always_comb begin
        state_d       = state_q;
        arm_entry     = 1'b0;
        clear_results = 1'b0;
        rec_time_d    = rec_time_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start && sw_idle) begin
                    state_d       = S_ARM;
                    arm_entry     = 1'b1;
                    clear_results = 1'b1;
                end
            end
            S_FOUL: begin
                // Retrying after a foul continues the same session.
                if (start && sw_idle) begin
                    state_d   = S_ARM;
                    arm_entry = 1'b1;
                end
            end
            S_ARM: begin
                if (start) begin
                    state_d   = S_ARM;
                    arm_entry = 1'b1;
                end else if (!sw_idle) begin
                    state_d = S_FOUL;
                end else if (!clreset && (count_bin == delay_q)) begin
                    state_d = S_WAIT_USER;
                end
            end
            S_WAIT_USER: begin
                if (start) begin
                    state_d   = S_ARM;
                    arm_entry = 1'b1;
                end else if (dec_wrong) begin
                    state_d = S_FOUL;
                end else if (dec_hit) begin
                    state_d    = S_RECORD;
                    rec_time_d = timed_out ? TIMEOUT_MS : count_bin;
                end else if (timed_out) begin
                    state_d    = S_RECORD;
                    rec_time_d = TIMEOUT_MS;
                end
            end
            S_RECORD: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (sw_idle) begin
                    if (round_idx == 3'(ROUNDS)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d   = S_ARM;
                        arm_entry = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wait_entry = (state_d == S_WAIT_USER) && (state_q != S_WAIT_USER);

        // The counter runs only while settled in ARM or WAIT_USER; every entry
        // into either holds it for one cycle so timing starts from zero.
        clreset_d = 1'b1;
        if (((state_d == S_ARM) && !arm_entry) ||
            ((state_d == S_WAIT_USER) && !wait_entry)) begin
            clreset_d = 1'b0;
        end
    end

    // Saturating accumulate; the carry bit flags overflow of the 24-bit total.
    assign sum_w = {1'b0, total} + {5'd0, rec_time_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            delay_q     <= '0;
            target_q    <= '0;
            rec_time_q  <= '0;
            clreset     <= 1'b1;
            led         <= LED_BLANK;
            false_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_time_q  <= rec_time_d;
            clreset     <= clreset_d;
            led         <= (state_d == S_WAIT_USER) ? dec_led : LED_BLANK;
            false_start <= (state_d == S_FOUL);
            done        <= (state_d == S_FINISH);
            if (arm_entry) begin
                delay_q  <= {5'd0, rand_num | MIN_DELAY};
                target_q <= wrap_target(rand_num[3:0]);
            end
        end
    end

    // Session results: cleared on a fresh session, updated during the single RECORD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_idx <= '0;
            last_time <= '0;
            total     <= '0;
            best      <= BEST_INIT;
        end else if (clear_results) begin
            round_idx <= '0;
            last_time <= '0;
            total     <= '0;
            best      <= BEST_INIT;
        end else if (state_q == S_RECORD) begin
            round_idx <= round_idx + 3'd1;
            last_time <= rec_time_q;
            total     <= sum_w[TOTAL_W] ? {TOTAL_W{1'b1}} : sum_w[TOTAL_W-1:0];
            if (rec_time_q < best) begin
                best <= rec_time_q;
            end
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed-vector bench for round_sequencer with hand-computed expectations.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_round_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  switch;
    logic [14:0] rand_num;
    logic [19:0] count_bin;
    logic        clreset;
    logic [9:0]  led;
    logic [2:0]  phase;
    logic [2:0]  round_idx;
    logic [19:0] last_time;
    logic [19:0] best;
    logic [23:0] total;
    logic        false_start;
    logic        done;

    int vec_cnt = 0;
    int err_cnt = 0;

    round_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .switch      (switch),
        .rand_num    (rand_num),
        .count_bin   (count_bin),
        .clreset     (clreset),
        .led         (led),
        .phase       (phase),
        .round_idx   (round_idx),
        .last_time   (last_time),
        .best        (best),
        .total       (total),
        .false_start (false_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered right after an ARM entry with count_bin = 0 and start = 0.
    task automatic play_round(input logic [19:0] dly, input logic [9:0] sw,
                              input logic [19:0] t, input string tag);
        step(1);
        count_bin = dly;
        step(1);
        chk({tag, "_wait"}, 32'(phase), 32'd2);
        count_bin = t;
        switch    = sw;
        step(1);
        chk({tag, "_rec"}, 32'(phase), 32'd3);
        step(1);
        chk({tag, "_last"}, 32'(last_time), 32'(t));
        switch    = '0;
        count_bin = '0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; switch = '0; rand_num = '0; count_bin = '0;
        step(2);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_clreset", 32'(clreset), 32'd1);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_best", 32'(best), 32'hFFFFF);
        chk("rst_total", 32'(total), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step(1);
        chk("idle_phase", 32'(phase), 32'd0);

        // First round: delay 0x405, target 5, hit at 250 ms.
        rand_num = 15'h0005; start = 1'b1;
        step(1);
        chk("arm_phase", 32'(phase), 32'd1);
        chk("arm_clreset_hi", 32'(clreset), 32'd1);
        start = 1'b0;
        step(1);
        chk("arm_clreset_lo", 32'(clreset), 32'd0);
        count_bin = 20'd1028;
        step(1);
        chk("arm_hold", 32'(phase), 32'd1);
        count_bin = 20'd1029;
        step(1);
        chk("wait_phase", 32'(phase), 32'd2);
        chk("wait_clreset", 32'(clreset), 32'd1);
        chk("wait_led", 32'(led), 32'h020);
        count_bin = 20'd0;
        step(1);
        chk("wait_run", 32'(clreset), 32'd0);
        count_bin = 20'd250; switch = 10'h020;
        step(1);
        chk("rec_phase", 32'(phase), 32'd3);
        chk("rec_led", 32'(led), 32'd0);
        step(1);
        chk("gap_phase", 32'(phase), 32'd4);
        chk("r1_last", 32'(last_time), 32'd250);
        chk("r1_best", 32'(best), 32'd250);
        chk("r1_total", 32'(total), 32'd250);
        chk("r1_idx", 32'(round_idx), 32'd1);
        switch = '0; count_bin = '0;
        step(1);
        chk("gap_to_arm", 32'(phase), 32'd1);

        // Switch during ARM is a false start; retry keeps the session.
        switch = 10'h004;
        step(1);
        chk("foul_phase", 32'(phase), 32'd5);
        chk("foul_flag", 32'(false_start), 32'd1);
        chk("foul_clreset", 32'(clreset), 32'd1);
        switch = '0; start = 1'b1; rand_num = 15'h0003;
        step(1);
        start = 1'b0;
        chk("retry_phase", 32'(phase), 32'd1);
        chk("retry_idx", 32'(round_idx), 32'd1);
        chk("retry_last", 32'(last_time), 32'd250);
        chk("retry_flag", 32'(false_start), 32'd0);

        // Target 3 with an extra switch in the same cycle is a foul.
        step(1);
        count_bin = 20'd1027;
        step(1);
        chk("t3_led", 32'(led), 32'h008);
        count_bin = '0; switch = 10'h088;
        step(1);
        chk("t3_foul", 32'(phase), 32'd5);
        chk("t3_idx", 32'(round_idx), 32'd1);

        // Timeout: nibble 0xC wraps to target 2, delay 0x40C.
        switch = '0; start = 1'b1; rand_num = 15'h000C;
        step(1);
        start = 1'b0;
        step(1);
        count_bin = 20'd1036;
        step(1);
        chk("to_led", 32'(led), 32'h004);
        count_bin = 20'd9998;
        step(1);
        chk("to_hold", 32'(phase), 32'd2);
        count_bin = 20'd9999;
        step(1);
        chk("to_rec", 32'(phase), 32'd3);
        count_bin = '0;
        step(1);
        chk("to_last", 32'(last_time), 32'd9999);
        chk("to_total", 32'(total), 32'd10249);
        chk("to_best", 32'(best), 32'd250);
        chk("to_idx", 32'(round_idx), 32'd2);
        step(1);
        chk("to_next_arm", 32'(phase), 32'd1);

        // Asynchronous reset while waiting for the user.
        step(1);
        count_bin = 20'd1036;
        step(1);
        chk("pre_rst_wait", 32'(phase), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_clreset", 32'(clreset), 32'd1);
        chk("arst_idx", 32'(round_idx), 32'd0);
        chk("arst_total", 32'(total), 32'd0);
        chk("arst_last", 32'(last_time), 32'd0);
        chk("arst_best", 32'(best), 32'hFFFFF);
        #1 rst = 1'b0;
        count_bin = '0;
        step(1);
        chk("post_rst_idle", 32'(phase), 32'd0);

        // Start with a switch held is refused.
        switch = 10'h200; start = 1'b1;
        step(1);
        chk("start_sw_held", 32'(phase), 32'd0);

        // Full five-round session with a mid-session restart.
        switch = '0; rand_num = 15'h0005;
        step(1);
        start = 1'b0;
        play_round(20'd1029, 10'h020, 20'd300, "s1");
        play_round(20'd1029, 10'h020, 20'd200, "s2");
        start = 1'b1; rand_num = 15'h000F;
        step(1);
        start = 1'b0;
        chk("restart_phase", 32'(phase), 32'd1);
        chk("restart_clreset", 32'(clreset), 32'd1);
        chk("restart_total", 32'(total), 32'd500);
        play_round(20'd1039, 10'h020, 20'd400, "s3");
        play_round(20'd1039, 10'h020, 20'd250, "s4");
        play_round(20'd1039, 10'h020, 20'd350, "s5");
        chk("fin_phase", 32'(phase), 32'd6);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_best", 32'(best), 32'd200);
        chk("fin_total", 32'(total), 32'd1500);
        chk("fin_idx", 32'(round_idx), 32'd5);
        chk("fin_clreset", 32'(clreset), 32'd1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("new_phase", 32'(phase), 32'd1);
        chk("new_idx", 32'(round_idx), 32'd0);
        chk("new_total", 32'(total), 32'd0);
        chk("new_best", 32'(best), 32'hFFFFF);
        chk("new_last", 32'(last_time), 32'd0);
        chk("new_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter ROUNDS, default 5: rounds per session, 1..7.
REQ-002 Parameter TIMEOUT_MS, default 20'd9999: maximum reaction time recorded in a round, in counter ticks (ms).
REQ-003 Parameter MIN_DELAY, default 15'h0400: OR-mask applied to the sampled random delay, so the minimum delay is 1024 ms.
REQ-004 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: synchronous, active-high start/restart request, sampled every cycle.
REQ-007 Port switch, input, 10: user switches, already synchronised.
REQ-008 Port rand_num, input, 15: free-running random value.
REQ-009 Port count_bin, input, 20: binary elapsed-ms value from the shared counter.
REQ-010 Port clreset, output, 1: holds the shared counter in reset while 1.
REQ-011 Port led, output, 10: one-hot target LED, or all zero.
REQ-012 Port phase, output, 3: current state encoding.
REQ-013 Port round_idx, output, 3: number of completed rounds.
REQ-014 Port last_time, output, 20: time of the most recent completed round.
REQ-015 Port best, output, 20: minimum round time in the session.
REQ-016 Port total, output, 24: sum of round times in the session.
REQ-017 Port false_start, output, 1: set while in FOUL.
REQ-018 Port done, output, 1: set while in FINISH.

Function
REQ-019 States SHALL be IDLE, ARM, WAIT_USER, RECORD, GAP, FOUL and FINISH; all outputs SHALL be registered.
REQ-020 IDLE/FINISH/FOUL + start + switch==0 -> ARM; IDLE/FINISH/FOUL + start + any switch set -> stay in the current state.
REQ-021 On every entry to ARM: delay_q <= rand_num | MIN_DELAY; target_q <= rand_num[3:0], minus 10 if >= 10; clreset = 1 for exactly one cycle, then 0.
REQ-022 Entry from IDLE/FINISH SHALL clear round_idx, total and last_time, and set best to 20'hFFFFF; entry from FOUL SHALL preserve all of them.
REQ-023 ARM: led = 0; with clreset = 0 and count_bin == delay_q -> WAIT_USER, with clreset = 1 for one cycle.
REQ-024 ARM, any switch set -> FOUL; this takes priority over the delay match in the same cycle.
REQ-025 WAIT_USER: led = one-hot(target_q); only the target switch set -> RECORD with time = count_bin.
REQ-026 WAIT_USER, any non-target switch set -> FOUL; this wins even if the target switch is set in the same cycle.
REQ-027 WAIT_USER, count_bin >= TIMEOUT_MS -> RECORD with time = TIMEOUT_MS.
REQ-028 RECORD lasts one cycle: last_time <= time; total <= total + time, saturating at 24'hFFFFFF; best <= min(best, time); round_idx += 1; clreset = 1; led = 0.
REQ-029 GAP: hold until switch==0; then round_idx == ROUNDS -> FINISH, otherwise -> ARM.
REQ-030 start asserted in ARM or WAIT_USER SHALL re-enter ARM with a fresh delay and target, leaving session totals unchanged.
REQ-031 start asserted in RECORD or GAP SHALL be ignored.
REQ-032 FOUL: led = 0; clreset = 1; the round is not counted.
REQ-033 FINISH: clreset = 1; led = 0; all results held.

Reset
REQ-034 rst = 1 SHALL force IDLE, clreset = 1, led = 0, round_idx = 0, last_time = 0, total = 0, best = 20'hFFFFF, false_start = 0 and done = 0, taking effect immediately and independent of clk.
REQ-035 Reset asserted mid-round SHALL discard the round in progress; the first state after reset deassertion is IDLE.

Structure
REQ-036 Shared package reaction_pkg SHALL hold the state enum, the 3-bit phase encodings, TIME_W = 20, the BEST_INIT constant and the blank-display constant.
REQ-037 One sub-module, target_decode, SHALL map the 4-bit target and 10-bit switch inputs to a 10-bit one-hot led, a hit flag and a wrong-switch flag.

Verification
REQ-038 Start pulse, rand_num = 15'h0005 -> delay 0x0405, target 5, WAIT_USER entered when count_bin = 1029; switch[5] set at count_bin = 250 -> last_time = 250, best = 250, total = 250, round_idx = 1.
REQ-039 switch[2] set during ARM -> FOUL with false_start = 1; a subsequent start pulse re-enters ARM with round_idx unchanged.
REQ-040 Target 3 with switch[3] and switch[7] set in the same cycle -> FOUL, not RECORD.
REQ-041 No switch activity in WAIT_USER until count_bin = 9999 -> last_time = 9999.
REQ-042 Five rounds with times 300, 200, 400, 250 and 350 -> done = 1, best = 200, total = 1500, round_idx = 5; a start pulse then clears the results.
REQ-043 rst asserted in WAIT_USER -> outputs take their reset values within the same cycle, and the next state is IDLE.
